varredura_display: RTL and testbench

VARREDURA_DISPLAY -- requirements
Module: varredura_display

---
 rtl/varredura_pkg.sv | 20 ++
 rtl/varredura_display_prescaler_tick.sv | 27 ++
 rtl/varredura_display.sv | 87 ++++++++
 tb/tb_varredura_display.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/varredura_pkg.sv
// Shared types and constants for the multiplexed 4-digit display scanner.
// Holds the anode-off pattern, digit count, digit index type and blanking helper.
package varredura_pkg;

   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam int         NDIG   = 4;

   typedef logic [1:0] dig_idx_t;

   // Bit i set when digit i is a leading zero (it and every higher digit are 0).
   function automatic logic [3:0] lz_mask(input logic [3:0][3:0] sh);
      logic [3:0] m;
      m[3] = (sh[3] == 4'd0);
      m[2] = m[3] && (sh[2] == 4'd0);
      m[1] = m[2] && (sh[1] == 4'd0);
      m[0] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/varredura_display_prescaler_tick.sv
// Digit-period prescaler: counts 0..DIV-1 on enabled cycles and flags the
// last count so the scanner advances exactly once per DIV enabled cycles.
module prescaler_tick #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic adv
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   assign adv = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= adv ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/varredura_display.sv
// Four-digit multiplexed display scanner with per-frame digit capture,
// optional leading-zero blanking and registered, edge-aligned outputs.
module varredura_display
   import varredura_pkg::*;
#(
   parameter int DIV  = 50000,
   parameter int NDIG = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       blank_lz,
   input  logic [3:0] dig0,
   input  logic [3:0] dig1,
   input  logic [3:0] dig2,
   input  logic [3:0] dig3,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic [3:0] an,
   output logic [1:0] dig_sel,
   output logic       tick
);

   if (NDIG != varredura_pkg::NDIG) begin : g_ndig_check
      $error("varredura_display: NDIG must be 4");
   end
   if (DIV < 2 || DIV > (1 << 20)) begin : g_div_check
      $error("varredura_display: DIV out of range 2..2^20");
   end

   logic             adv;
   logic             load_pend;
   dig_idx_t         sel_q;
   dig_idx_t         next_sel;
   logic             frame_start;
   logic [3:0][3:0]  sh_q;
   logic [3:0][3:0]  sh_next;
   logic [3:0]       lz;
   logic [3:0]       an_next;

   prescaler_tick #(.DIV(DIV)) u_prescaler (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .adv (adv)
   );

   // Outputs are computed from the post-edge digit and the post-edge shadows,
   // so a freshly captured dig0 is shown on the very edge it is latched.
   always_comb begin
      frame_start = en && ((adv && (sel_q == dig_idx_t'(3))) || load_pend);
      next_sel    = adv ? sel_q + dig_idx_t'(1) : sel_q;
      sh_next     = frame_start ? {dig3, dig2, dig1, dig0} : sh_q;
      lz          = lz_mask(sh_next);
      an_next     = ~(4'b0001 << next_sel);
      if (blank_lz && lz[next_sel]) begin
         an_next = AN_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q        <= '0;
         sh_q         <= '0;
         {A, B, C, D} <= 4'd0;
         an           <= AN_OFF;
         tick         <= 1'b0;
         load_pend    <= 1'b1;
      end else begin
         tick      <= adv;
         load_pend <= load_pend && !en;
         if (en) begin
            sel_q        <= next_sel;
            sh_q         <= sh_next;
            {A, B, C, D} <= sh_next[next_sel];
            an           <= an_next;
         end else begin
            an <= AN_OFF;
         end
      end
   end

   assign dig_sel = sel_q;

endmodule

// File: tb/tb_varredura_display.sv
// Directed checks of the display scanner at DIV=4 plus a randomised run at
// DIV=2 against a small reference model of the scan behaviour.
module tb_varredura_display;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // DIV=4 instance for directed vectors
   logic       rst4, en4, blz4;
   logic [3:0] a0, a1, a2, a3;
   logic       A4, B4, C4, D4, tick4;
   logic [3:0] an4;
   logic [1:0] sel4;

   varredura_display #(.DIV(4), .NDIG(4)) u4 (
      .clk(clk), .rst(rst4), .en(en4), .blank_lz(blz4),
      .dig0(a0), .dig1(a1), .dig2(a2), .dig3(a3),
      .A(A4), .B(B4), .C(C4), .D(D4),
      .an(an4), .dig_sel(sel4), .tick(tick4)
   );

   // DIV=2 instance for random stimulus
   logic       rst2, en2, blz2;
   logic [3:0] b0, b1, b2, b3;
   logic       A2, B2, C2, D2, tick2;
   logic [3:0] an2;
   logic [1:0] sel2;

   varredura_display #(.DIV(2), .NDIG(4)) u2 (
      .clk(clk), .rst(rst2), .en(en2), .blank_lz(blz2),
      .dig0(b0), .dig1(b1), .dig2(b2), .dig3(b3),
      .A(A2), .B(B2), .C(C2), .D(D2),
      .an(an2), .dig_sel(sel2), .tick(tick2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input int sel, input logic [3:0] an,
                       input logic [3:0] abcd, input logic tk);
      check({tag, "_sel"},  32'(sel4), 32'(sel));
      check({tag, "_an"},   32'(an4), 32'(an));
      check({tag, "_abcd"}, 32'({A4, B4, C4, D4}), 32'(abcd));
      check({tag, "_tick"}, 32'(tick4), 32'(tk));
   endtask

   // Reset, load four digits, scan one full frame and return to digit 0.
   task automatic scan_frame(input string tag, input logic blz,
                             input logic [3:0] v0, input logic [3:0] v1,
                             input logic [3:0] v2, input logic [3:0] v3,
                             input logic [15:0] exp_an);
      logic [3:0] v [4];
      int sel;
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      rst4 = 1'b1; en4 = 1'b0; blz4 = blz;
      a0 = v0; a1 = v1; a2 = v2; a3 = v3;
      step();
      rst4 = 1'b0; en4 = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         sel = (k / 4) % 4;
         chk4(tag, sel, exp_an[sel*4 +: 4], v[sel], (k % 4) == 0);
      end
   endtask

   // Reference model state for the DIV=2 instance
   int         m_cnt, m_sel;
   logic [3:0] m_sh [4];
   logic [3:0] m_abcd, m_an;
   logic       m_tick, m_lp;

   task automatic model_edge();
      logic adv, fs, lead;
      if (rst2) begin
         m_cnt = 0; m_sel = 0; m_abcd = 4'd0; m_an = 4'hF; m_tick = 1'b0; m_lp = 1'b1;
         for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
      end else begin
         adv = en2 && (m_cnt == 1);
         fs  = (adv && m_sel == 3) || (en2 && m_lp);
         m_tick = adv;
         if (en2) begin
            m_cnt = adv ? 0 : m_cnt + 1;
            if (fs) begin
               m_sh[0] = b0; m_sh[1] = b1; m_sh[2] = b2; m_sh[3] = b3;
            end
            if (adv) m_sel = (m_sel + 1) % 4;
            m_abcd = m_sh[m_sel];
            lead = 1'b1;
            for (int i = 3; i >= m_sel; i--) lead = lead && (m_sh[i] == 4'd0);
            m_an = (blz2 && m_sel != 0 && lead) ? 4'hF : ~(4'b0001 << m_sel);
            m_lp = 1'b0;
         end else begin
            m_an = 4'hF;
         end
      end
   endtask

   function automatic logic [3:0] rnd_dig();
      return ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
   endfunction

   initial begin
      logic [3:0] old_v [4];
      logic [3:0] new_v [4];
      int sel, zc;

      old_v[0] = 4'd1; old_v[1] = 4'd2; old_v[2] = 4'd3; old_v[3] = 4'd4;
      new_v[0] = 4'd9; new_v[1] = 4'd2; new_v[2] = 4'd3; new_v[3] = 4'd8;

      rst4 = 1'b1; en4 = 1'b0; blz4 = 1'b0;
      a0 = 4'd1; a1 = 4'd2; a2 = 4'd3; a3 = 4'd4;
      rst2 = 1'b1; en2 = 1'b0; blz2 = 1'b0;
      b0 = 4'd0; b1 = 4'd0; b2 = 4'd0; b3 = 4'd0;

      step(); step();
      chk4("reset", 0, 4'hF, 4'd0, 1'b0);

      // Basic scan; dig0/dig3 change mid-frame and appear only on next frame
      rst4 = 1'b0; en4 = 1'b1;
      for (int k = 1; k <= 53; k++) begin
         step();
         sel = (k / 4) % 4;
         chk4("scan", sel, ~(4'b0001 << sel), (k >= 32) ? new_v[sel] : old_v[sel], (k % 4) == 0);
         if (k == 24) begin
            a0 = 4'd9; a3 = 4'd8;
         end
      end

      // Freeze mid digit 1 (two cycles already shown)
      en4 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk4("hold", 1, 4'hF, 4'd2, 1'b0);
      end
      en4 = 1'b1;
      step(); chk4("resume1", 1, 4'b1101, 4'd2, 1'b0);
      step(); chk4("resume2", 1, 4'b1101, 4'd2, 1'b0);
      step(); chk4("resume3", 2, 4'b1011, 4'd3, 1'b1);
      repeat (4) step();
      chk4("dig3", 3, 4'b0111, 4'd8, 1'b1);

      // Reset mid digit 3 restarts with a fresh capture
      a0 = 4'd6; a1 = 4'd5; a2 = 4'd4; a3 = 4'd3;
      step(); chk4("midframe", 3, 4'b0111, 4'd8, 1'b0);
      rst4 = 1'b1;
      step(); chk4("rst_mid", 0, 4'hF, 4'd0, 1'b0);
      rst4 = 1'b0;
      step(); chk4("restart", 0, 4'b1110, 4'd6, 1'b0);
      repeat (3) step();
      chk4("restart_d1", 1, 4'b1101, 4'd5, 1'b1);

      // Leading-zero blanking
      scan_frame("lz5",   1'b1, 4'd5, 4'd0, 4'd0, 4'd0, {4'hF, 4'hF, 4'hF, 4'hE});
      scan_frame("lz7",   1'b1, 4'd0, 4'd0, 4'd7, 4'd0, {4'hF, 4'hB, 4'hD, 4'hE});
      scan_frame("lz0",   1'b1, 4'd0, 4'd0, 4'd0, 4'd0, {4'hF, 4'hF, 4'hF, 4'hE});
      scan_frame("lzd3",  1'b1, 4'd0, 4'd0, 4'd0, 4'd1, {4'h7, 4'hB, 4'hD, 4'hE});
      scan_frame("nolz",  1'b0, 4'd0, 4'd0, 4'd0, 4'd0, {4'h7, 4'hB, 4'hD, 4'hE});

      // Random run on the DIV=2 instance
      for (int k = 0; k < 10000; k++) begin
         model_edge();
         step();
         zc = 0;
         for (int i = 0; i < 4; i++) if (an2[i] == 1'b0) zc++;
         check("rnd_one_anode", 32'(zc <= 1), 32'd1);
         check("rnd_abcd", 32'({A2, B2, C2, D2}), 32'(m_abcd));
         check("rnd_an",   32'(an2), 32'(m_an));
         check("rnd_sel",  32'(sel2), 32'(m_sel));
         check("rnd_tick", 32'(tick2), 32'(m_tick));
         rst2 = ($urandom_range(0, 299) == 0);
         en2  = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 49) == 0) blz2 = ~blz2;
         b0 = rnd_dig(); b1 = rnd_dig(); b2 = rnd_dig(); b3 = rnd_dig();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
